// File: rtl/mem_ctrl64_pkg.sv
// Shared widths and FSM state encoding for the mem_ctrl64 RAM front end.
package mem_ctrl64_pkg;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/mem_ctrl64_if.sv
// CPU-side request/response channel of mem_ctrl64 (valid/ready on both directions).
interface mem_ctrl64_if;
  import mem_ctrl64_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_ctrl64.sv
// Request/response front end for the 64x16 RAM: turns valid/ready requests into
// load/address/in strobes, registers read data, and zero-fills the RAM on reset or demand.
module mem_ctrl64
  import mem_ctrl64_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_ctrl64_if.slave   bus,
  input  logic          clear_req,
  output logic          busy,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_out
);

  state_t        state, state_n;
  logic [AW-1:0] clr_cnt, clr_cnt_n;
  logic [AW-1:0] a_q, a_n;
  logic [DW-1:0] d_q, d_n;
  logic [DW-1:0] rdata_q, rdata_n;
  logic          req_ready_c;
  logic          rsp_valid_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      a_q     <= a_n;
      d_q     <= d_n;
      rdata_q <= rdata_n;
    end
  end

  // RAM strobes depend only on registered state, so a request never reaches the RAM combinationally.
  always_comb begin
    state_n     = state;
    clr_cnt_n   = clr_cnt;
    a_n         = a_q;
    d_n         = d_q;
    rdata_n     = rdata_q;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    busy        = 1'b0;
    mem_load    = 1'b0;
    mem_addr    = a_q;
    mem_in      = '0;

    case (state)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_load  = 1'b1;
        mem_addr  = clr_cnt;
        clr_cnt_n = clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready_c = ~clear_req;
        if (clear_req) begin
          state_n = ST_CLEAR;
        end else if (bus.req_valid) begin
          a_n     = bus.req_addr;
          d_n     = bus.req_wdata;
          state_n = bus.req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        mem_load = 1'b1;
        mem_in   = d_q;
        state_n  = ST_IDLE;
      end
      ST_READ: begin
        rdata_n = mem_out;
        state_n = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl64.sv
// Scoreboard bench for mem_ctrl64 paired with a behavioural 64x16 RAM.
module tb_mem_ctrl64;
  import mem_ctrl64_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          busy;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_out;

  mem_ctrl64_if bus();

  mem_ctrl64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clear_req (clear_req),
    .busy      (busy),
    .mem_in    (mem_in),
    .mem_load  (mem_load),
    .mem_addr  (mem_addr),
    .mem_out   (mem_out)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;
  assign mem_out = ram[mem_addr];

  always #5 clk = ~clk;

  int            compared = 0;
  int            mismatched = 0;
  int            cycle = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [DEPTH];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each response handshake consumes one expected word.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rsp", {16'h0, bus.rsp_rdata}, 32'hDEAD_0000);
      end else begin
        check_output("rsp_rdata", {16'h0, bus.rsp_rdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic check_clear_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      check_output("clear_sweep", {8'h0, busy, mem_load, mem_addr, mem_in},
                   {8'h0, 1'b1, 1'b1, 6'(i), 16'h0});
      step();
    end
    check_output("clear_done_busy", {31'h0, busy}, 32'h0);
    check_output("clear_done_ready", {31'h0, bus.req_ready}, 32'h1);
  endtask

  task automatic apply_stimulus(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, output int accept_cycle);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (!bus.req_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check_output("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
    accept_cycle = cycle;
    if (we) model[addr] = data;
    else    exp_q.push_back(model[addr]);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 500) begin
      step();
      n++;
    end
    check_output("drain", {31'h0, (exp_q.size() == 0)}, 32'h1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, prev;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    clear_model();

    repeat (3) step();
    check_output("reset_outputs",
                 {26'h0, bus.req_ready, bus.rsp_valid, busy, mem_load, (mem_addr == 6'd0), (mem_in == 16'h0)},
                 {26'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
    rst_n = 1'b1;
    check_clear_sweep();
    apply_stimulus(1'b0, 6'h3F, 16'h0, acc);
    wait_drained();

    apply_stimulus(1'b1, 6'h05, 16'hBEEF, acc);
    apply_stimulus(1'b0, 6'h05, 16'h0, acc);
    check_output("lat_accept_plus1", {31'h0, bus.rsp_valid}, 32'h0);
    step();
    check_output("lat_accept_plus2", {31'h0, bus.rsp_valid}, 32'h1);
    wait_drained();

    bus.rsp_ready = 1'b0;
    apply_stimulus(1'b0, 6'h05, 16'h0, acc);
    step();
    for (int i = 0; i < 5; i++) begin
      check_output("stall_hold", {14'h0, bus.rsp_valid, bus.req_ready, bus.rsp_rdata},
                   {14'h0, 1'b1, 1'b0, 16'hBEEF});
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check_output("stall_release", {30'h0, bus.rsp_valid, bus.req_ready}, {30'h0, 1'b0, 1'b1});

    clear_req     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'h05;
    #1;
    check_output("clear_blocks_ready", {31'h0, bus.req_ready}, 32'h0);
    step();
    check_output("clear_started", {31'h0, busy}, 32'h1);
    clear_req     = 1'b0;
    bus.req_valid = 1'b0;
    clear_model();
    check_clear_sweep();
    apply_stimulus(1'b0, 6'h05, 16'h0, acc);
    wait_drained();

    apply_stimulus(1'b1, 6'h3F, 16'h1234, acc);
    bus.rsp_ready = 1'b0;
    apply_stimulus(1'b0, 6'h3F, 16'h0, acc);
    step();
    check_output("resp_before_reset", {31'h0, bus.rsp_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("reset_in_resp", {29'h0, bus.rsp_valid, busy, (mem_addr == 6'd0)}, {29'h0, 1'b0, 1'b1, 1'b1});
    exp_q.delete();
    clear_model();
    step();
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    check_clear_sweep();

    prev = 0;
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 6'(i), 16'(i * 3), acc);
      if (i > 0) check_output("write_gap", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 6'(i), 16'h0, acc);
    wait_drained();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
